tune_sequencer: RTL and testbench
=================================

Name: tune_sequencer

Overview:
Note-sequencing controller for the play-tune speaker datapath. It walks a melody table, converts each entry into a tone half-period plus an enable, and times note and gap durations in beats. Its outputs drive the tone generator that toggles the 2-bit differential speaker. It sits between the io_in control bits and the tone/speaker stage.

Parameters:
BEAT_COUNT, 100, clk cycles per beat (kept small so simulation stays fast)
GAP_BEATS, 1, silent beats inserted after every note (0 = legato, no gap)
ADDR_W, 4, melody table address width (NOTE_COUNT = 2**ADDR_W)
PERIOD_W, 12, tone half-period width in clk cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  level; begin playback from entry 0 when idle
stop  in  1  level; abort playback
loop_en  in  1  at end of tune, restart at entry 0 instead of finishing
tone_en  out  1  tone generator enable (0 = silence)
tone_half_period  out  PERIOD_W  half-period to the tone generator
note_addr  out  ADDR_W  current melody table address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the tune finishes normally

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, internal counters 0.
- Entry format, 8 bits: [7:4] pitch code (0 = rest), [3:0] length in beats (0 = end-of-tune marker).
- States: IDLE, LOAD, PLAY, GAP, DONE. All outputs are registered.
- IDLE: start=1 and stop=0 -> LOAD with note_addr=0.
- LOAD (1 cycle): reads the table combinationally at note_addr.
  - Length 0, or note_addr already wrapped past NOTE_COUNT-1 -> end of tune.
  - End of tune with loop_en=1 and note_addr!=0 -> note_addr=0, stay in LOAD.
  - End of tune otherwise, including a marker at entry 0 -> DONE.
  - Normal entry -> latch tone_half_period=PITCH_LUT[pitch], tone_en=(pitch!=0), beats_left=length, clear the prescaler, go to PLAY.
- Latency: start sampled high at cycle N -> LOAD at N+1 -> tone_en/tone_half_period valid from N+2.
- PLAY: prescaler counts 0..BEAT_COUNT-1 and wraps. On each wrap beats_left decrements. PLAY lasts exactly length*BEAT_COUNT cycles.
- Leaving PLAY on the final wrap:
  - GAP_BEATS>0 -> GAP with tone_en=0 and the prescaler cleared.
  - GAP_BEATS=0 -> LOAD with note_addr+1.
- GAP: lasts GAP_BEATS*BEAT_COUNT cycles with tone_en=0, then LOAD with note_addr+1.
- Address increment from NOTE_COUNT-1 sets an internal wrapped flag. The next LOAD treats it as end of tune.
- DONE (1 cycle): done=1, tone_en=0, then IDLE.
- stop=1 in any non-IDLE state -> IDLE next cycle: tone_en=0, busy=0, no done pulse, note_addr held.
- Priorities:
  - stop overrides start.
  - start is ignored while busy.
  - A level-held start re-triggers from IDLE on the cycle after DONE.
- Reset mid-playback: immediate return to reset values; no done pulse.

Decomposition:
- Package tune_pkg:
  - state enum
  - entry field positions and widths
  - PITCH_LUT constant: 16 x PERIOD_W; [0]=0, [1]=12'd956, [2]=12'd851, [3]=12'd758, ...
  - default melody TUNE: entry0=0x12, entry1=0x01, entry2=0x31, entry3=0x00
- One sub-module, tune_rom: combinational address -> 8-bit entry from TUNE.
- The sequencer holds the FSM, prescaler, beat counters and address register.

Test Plan:
1. BEAT_COUNT=4, GAP_BEATS=1; assert rst=0 mid-PLAY -> outputs 0 without waiting for a clk edge; after release, busy=0 until start.
2. Pulse start at cycle N -> tone_en=1 and tone_half_period=956 from N+2 for 8 cycles, then 4 cycles of tone_en=0 (GAP), then entry1: tone_en=0 for 4 cycles (rest), note_addr=1.
3. Default tune, loop_en=0 -> after entry2 (half_period=758 for 4 cycles, then gap), LOAD sees 0x00 at note_addr=3 -> done=1 for exactly one cycle, then busy=0.
4. loop_en=1 -> after entry2's gap, note_addr returns to 0 and tone_half_period=956 again; done stays 0 across three loops.
5. stop=1 for one cycle during PLAY of entry0 -> next cycle tone_en=0, busy=0, done=0; start and stop asserted together in IDLE -> stays IDLE.
6. GAP_BEATS=0 -> entry0 to entry1 transition has exactly one LOAD cycle between PLAY states; total tune time = (2+1+1)*4 + 3 LOAD cycles + 1 final LOAD.

Source files
------------

// File: rtl/tune_pkg.sv
// Shared types and constants for the tune sequencer: FSM states, melody entry layout,
// the pitch-to-half-period table and the default melody.
package tune_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPlay,
        StGap,
        StDone
    } state_e;

    localparam int unsigned EntryW = 8;
    localparam int unsigned PitchW = 4;
    localparam int unsigned LenW   = 4;
    localparam int unsigned LutW   = 12;

    // Pitch code in the upper nibble, length in beats in the lower nibble.
    typedef struct packed {
        logic [PitchW-1:0] pitch;
        logic [LenW-1:0]   len;
    } entry_t;

    localparam logic [LutW-1:0] PitchLut [16] = '{
        12'd0,   12'd956, 12'd851, 12'd758, 12'd716, 12'd638, 12'd568, 12'd506,
        12'd478, 12'd426, 12'd379, 12'd358, 12'd319, 12'd284, 12'd253, 12'd239
    };

    localparam int unsigned TuneLen = 4;
    localparam logic [EntryW-1:0] Tune [TuneLen] = '{8'h12, 8'h01, 8'h31, 8'h00};

    function automatic logic [LutW-1:0] pitch_period(input logic [PitchW-1:0] pitch);
        return PitchLut[pitch];
    endfunction

endpackage

// File: rtl/tune_sequencer_if.sv
// Control and tone-output bundle between the io_in control bits, the sequencer and the
// tone generator.
interface tune_sequencer_if #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned PERIOD_W = 12
) ();
    logic                start;
    logic                stop;
    logic                loop_en;
    logic                tone_en;
    logic [PERIOD_W-1:0] tone_half_period;
    logic [ADDR_W-1:0]   note_addr;
    logic                busy;
    logic                done;

    modport master (
        output start, stop, loop_en,
        input  tone_en, tone_half_period, note_addr, busy, done
    );

    modport slave (
        input  start, stop, loop_en,
        output tone_en, tone_half_period, note_addr, busy, done
    );
endinterface

// File: rtl/tune_rom.sv
// Melody table: combinational address to 8-bit entry; unused addresses read as the
// end-of-tune marker.
module tune_rom
    import tune_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [EntryW-1:0] entry_o
);

    always_comb begin
        entry_o = '0;
        for (int unsigned i = 0; i < TuneLen; i++) begin
            if (addr_i == ADDR_W'(i)) begin
                entry_o = Tune[i];
            end
        end
    end

endmodule

// File: rtl/tune_sequencer.sv
// Note sequencer: walks the melody table and times notes and gaps in beats, driving the
// tone generator with registered enable and half-period.
module tune_sequencer
    import tune_pkg::*;
#(
    parameter int unsigned BEAT_COUNT = 100,
    parameter int unsigned GAP_BEATS  = 1,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned PERIOD_W   = 12
) (
    input logic              clk,
    input logic              rst,
    tune_sequencer_if.slave  bus
);

    localparam int unsigned       PrescW   = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(BEAT_COUNT - 1);
    localparam logic [ADDR_W-1:0] AddrMax  = {ADDR_W{1'b1}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wrapped_q, wrapped_d;
    logic [PrescW-1:0]   presc_q, presc_d;
    logic [7:0]          beats_q, beats_d;
    logic                tone_en_q, tone_en_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [EntryW-1:0]   entry_raw;
    entry_t              entry;
    logic                beat_wrap;
    logic                last_beat;

    tune_rom #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .addr_i  (addr_q),
        .entry_o (entry_raw)
    );

    assign entry = entry_t'(entry_raw);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        presc_d   = presc_q;
        beats_d   = beats_q;
        tone_en_d = tone_en_q;
        half_d    = half_q;
        done_d    = 1'b0;
        beat_wrap = (presc_q == PrescMax);
        last_beat = beat_wrap && (beats_q == 8'd1);

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.stop) begin
                    state_d   = StLoad;
                    addr_d    = '0;
                    wrapped_d = 1'b0;
                end
            end
            StLoad: begin
                if (entry.len == '0 || wrapped_q) begin
                    if (bus.loop_en && addr_q != '0) begin
                        addr_d    = '0;
                        wrapped_d = 1'b0;
                    end else begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        tone_en_d = 1'b0;
                    end
                end else begin
                    half_d    = PERIOD_W'(pitch_period(entry.pitch));
                    tone_en_d = (entry.pitch != '0);
                    beats_d   = 8'(entry.len);
                    presc_d   = '0;
                    state_d   = StPlay;
                end
            end
            StPlay, StGap: begin
                presc_d = beat_wrap ? '0 : presc_q + 1'b1;
                if (beat_wrap) begin
                    beats_d = beats_q - 8'd1;
                end
                if (last_beat) begin
                    tone_en_d = 1'b0;
                    if (state_q == StPlay && GAP_BEATS > 0) begin
                        state_d = StGap;
                        beats_d = 8'(GAP_BEATS);
                        presc_d = '0;
                    end else begin
                        // Stepping past the last table slot marks the tune as finished.
                        state_d = StLoad;
                        addr_d  = addr_q + 1'b1;
                        if (addr_q == AddrMax) begin
                            wrapped_d = 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (bus.stop && state_q != StIdle) begin
            state_d   = StIdle;
            tone_en_d = 1'b0;
            done_d    = 1'b0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wrapped_q <= 1'b0;
            presc_q   <= '0;
            beats_q   <= '0;
            tone_en_q <= 1'b0;
            half_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
            presc_q   <= presc_d;
            beats_q   <= beats_d;
            tone_en_q <= tone_en_d;
            half_q    <= half_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.tone_en          = tone_en_q;
    assign bus.tone_half_period = half_q;
    assign bus.note_addr        = addr_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer: one instance with a one-beat gap, one legato instance,
// both at four clocks per beat.
module tb_tune_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tune_sequencer_if #(.ADDR_W(4), .PERIOD_W(12)) bus_a ();
    tune_sequencer_if #(.ADDR_W(4), .PERIOD_W(12)) bus_b ();

    tune_sequencer #(
        .BEAT_COUNT (4),
        .GAP_BEATS  (1),
        .ADDR_W     (4),
        .PERIOD_W   (12)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    tune_sequencer #(
        .BEAT_COUNT (4),
        .GAP_BEATS  (0),
        .ADDR_W     (4),
        .PERIOD_W   (12)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Steps dut_a n cycles, checking its outputs after every edge.
    task automatic span_a(input string tag, input int n, input logic ten,
                          input logic [11:0] half, input logic [3:0] addr);
        for (int i = 0; i < n; i++) begin
            cyc();
            check({tag, " tone_en"}, 32'(bus_a.tone_en), 32'(ten));
            check({tag, " half"}, 32'(bus_a.tone_half_period), 32'(half));
            check({tag, " addr"}, 32'(bus_a.note_addr), 32'(addr));
            check({tag, " busy"}, 32'(bus_a.busy), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  t_done;
        bit  seen_done;

        bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.loop_en = 1'b0;
        bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.loop_en = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc();

        check("reset busy", 32'(bus_a.busy), 32'd0);
        check("reset tone_en", 32'(bus_a.tone_en), 32'd0);
        check("reset half", 32'(bus_a.tone_half_period), 32'd0);
        check("reset addr", 32'(bus_a.note_addr), 32'd0);
        check("reset done", 32'(bus_a.done), 32'd0);

        // Asynchronous reset in the middle of a note
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        check("load busy", 32'(bus_a.busy), 32'd1);
        check("load tone_en", 32'(bus_a.tone_en), 32'd0);
        cyc();
        check("play tone_en", 32'(bus_a.tone_en), 32'd1);
        cyc(2);
        #2 rst = 1'b0;
        #1;
        check("async rst tone_en", 32'(bus_a.tone_en), 32'd0);
        check("async rst busy", 32'(bus_a.busy), 32'd0);
        check("async rst half", 32'(bus_a.tone_half_period), 32'd0);
        check("async rst addr", 32'(bus_a.note_addr), 32'd0);
        #1 rst = 1'b1;
        cyc();
        check("post rst busy", 32'(bus_a.busy), 32'd0);
        cyc(3);
        check("idle busy", 32'(bus_a.busy), 32'd0);

        // Full tune with gaps, no loop
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        check("t0 addr", 32'(bus_a.note_addr), 32'd0);
        check("t0 busy", 32'(bus_a.busy), 32'd1);
        span_a("e0 play", 8, 1'b1, 12'd956, 4'd0);
        span_a("e0 gap", 4, 1'b0, 12'd956, 4'd0);
        span_a("e1 load", 1, 1'b0, 12'd956, 4'd1);
        span_a("e1 rest", 4, 1'b0, 12'd0, 4'd1);
        span_a("e1 gap", 4, 1'b0, 12'd0, 4'd1);
        span_a("e2 load", 1, 1'b0, 12'd0, 4'd2);
        span_a("e2 play", 4, 1'b1, 12'd758, 4'd2);
        span_a("e2 gap", 4, 1'b0, 12'd758, 4'd2);
        span_a("e3 load", 1, 1'b0, 12'd758, 4'd3);
        cyc();
        check("done pulse", 32'(bus_a.done), 32'd1);
        check("done busy", 32'(bus_a.busy), 32'd1);
        check("done tone_en", 32'(bus_a.tone_en), 32'd0);
        cyc();
        check("after done", 32'(bus_a.done), 32'd0);
        check("after done busy", 32'(bus_a.busy), 32'd0);
        cyc();
        check("done single", 32'(bus_a.done), 32'd0);

        // Stop during entry0 play
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        cyc(3);
        bus_a.stop = 1'b1;
        cyc();
        bus_a.stop = 1'b0;
        check("stop tone_en", 32'(bus_a.tone_en), 32'd0);
        check("stop busy", 32'(bus_a.busy), 32'd0);
        check("stop done", 32'(bus_a.done), 32'd0);

        // start together with stop in idle is ignored
        bus_a.start = 1'b1;
        bus_a.stop  = 1'b1;
        cyc(2);
        check("start+stop busy", 32'(bus_a.busy), 32'd0);
        bus_a.stop = 1'b0;
        cyc();
        bus_a.start = 1'b0;

        // Stop during entry2 play holds the address
        cyc(24);
        check("e2 before stop", 32'(bus_a.tone_half_period), 32'd758);
        bus_a.stop = 1'b1;
        cyc();
        bus_a.stop = 1'b0;
        check("stop2 addr held", 32'(bus_a.note_addr), 32'd2);
        check("stop2 busy", 32'(bus_a.busy), 32'd0);
        check("stop2 tone_en", 32'(bus_a.tone_en), 32'd0);
        cyc();
        check("stop2 no done", 32'(bus_a.done), 32'd0);

        // Looping: period of 32 cycles per pass
        bus_a.loop_en = 1'b1;
        bus_a.start   = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        seen_done = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            cyc();
            if (bus_a.done) seen_done = 1'b1;
            if (t == 31) check("loop t31 addr", 32'(bus_a.note_addr), 32'd3);
            if (t == 32) begin
                check("loop t32 addr", 32'(bus_a.note_addr), 32'd0);
                check("loop t32 tone_en", 32'(bus_a.tone_en), 32'd0);
            end
            if (t == 33 || t == 65 || t == 97) begin
                check("loop replay half", 32'(bus_a.tone_half_period), 32'd956);
                check("loop replay tone_en", 32'(bus_a.tone_en), 32'd1);
            end
        end
        check("loop no done", 32'(seen_done), 32'd0);
        check("loop busy", 32'(bus_a.busy), 32'd1);
        bus_a.stop = 1'b1;
        cyc();
        bus_a.stop    = 1'b0;
        bus_a.loop_en = 1'b0;
        check("loop stop busy", 32'(bus_a.busy), 32'd0);

        // Legato instance, start held high through the end of the tune
        bus_b.start = 1'b1;
        cyc();
        t_done = -1;
        for (int t = 1; t <= 60; t++) begin
            cyc();
            if (t == 8) begin
                check("b t8 tone_en", 32'(bus_b.tone_en), 32'd1);
                check("b t8 half", 32'(bus_b.tone_half_period), 32'd956);
            end
            if (t == 9) begin
                check("b t9 addr", 32'(bus_b.note_addr), 32'd1);
                check("b t9 tone_en", 32'(bus_b.tone_en), 32'd0);
            end
            if (t == 10) check("b t10 rest", 32'(bus_b.tone_en), 32'd0);
            if (t == 14) check("b t14 addr", 32'(bus_b.note_addr), 32'd2);
            if (t == 15) check("b t15 half", 32'(bus_b.tone_half_period), 32'd758);
            if (t == 19) check("b t19 addr", 32'(bus_b.note_addr), 32'd3);
            if (bus_b.done) begin
                t_done = t;
                break;
            end
        end
        check("b done cycle", 32'(t_done), 32'd20);
        cyc();
        check("b idle busy", 32'(bus_b.busy), 32'd0);
        check("b idle done", 32'(bus_b.done), 32'd0);
        cyc();
        check("b retrigger busy", 32'(bus_b.busy), 32'd1);
        check("b retrigger addr", 32'(bus_b.note_addr), 32'd0);
        bus_b.start = 1'b0;
        bus_b.stop  = 1'b1;
        cyc();
        bus_b.stop = 1'b0;
        check("b stop busy", 32'(bus_b.busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
